fetch_stage: RTL and testbench

Instruction-fetch stage with an integrated IF/ID pipeline register for the 5-stage RV32I core. It owns the fetch PC, issues one request at a time to the instruction memory over a valid/ready handshake, and accepts a variable-latency response. It delivers `instrD`, `pcD` and `pcPlus4D` to the decode stage, where the immediate generator and control decoder consume them. Decode stall, branch/jump redirect flush and a one-entry holding buffer are handled internally.

---
 rtl/fetch_stage.sv | 156 +++++++++++++++
 tb/tb_fetch_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage with integrated IF/ID register.
// One outstanding imem request; holding buffer absorbs a stalled response.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        stallD,
  input  logic        flushE,
  input  logic [31:0] pcTargetE,
  output logic        imemReqValid,
  output logic [31:0] imemReqAddr,
  input  logic        imemReqReady,
  input  logic        imemRspValid,
  input  logic [31:0] imemRspData,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pcPlus4D,
  output logic        validD
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] pc_inf_q, pc_inf_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] instr_id_q, instr_id_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] pc4_id_q, pc4_id_d;
  logic        valid_id_q, valid_id_d;

  logic        load;
  logic [31:0] ld_instr;
  logic [31:0] ld_pc;
  logic [31:0] pc_inf_p4;

  assign pc_inf_p4 = pc_inf_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_f_d      = pc_f_q;
    pc_inf_d    = pc_inf_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    load        = 1'b0;
    ld_instr    = buf_instr_q;
    ld_pc       = buf_pc_q;
    unique case (state_q)
      S_REQ: begin
        if (flushE) begin
          pc_f_d  = pcTargetE;
          state_d = imemReqReady ? S_DROP : S_REQ;
        end else if (imemReqReady) begin
          pc_inf_d = pc_f_q;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flushE) begin
          pc_f_d  = pcTargetE;
          state_d = imemRspValid ? S_REQ : S_DROP;
        end else if (imemRspValid) begin
          pc_f_d = pc_inf_p4;
          if (stallD) begin
            buf_instr_d = imemRspData;
            buf_pc_d    = pc_inf_q;
            state_d     = S_HOLD;
          end else begin
            load     = 1'b1;
            ld_instr = imemRspData;
            ld_pc    = pc_inf_q;
            state_d  = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (flushE) begin
          pc_f_d  = pcTargetE;
          state_d = S_REQ;
        end else if (!stallD) begin
          load    = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (flushE) pc_f_d = pcTargetE;
        if (imemRspValid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
    // a redirect empties the holding buffer
    if (flushE) begin
      buf_instr_d = NOP_INSTR;
      buf_pc_d    = 32'd0;
    end
  end

  always_comb begin
    instr_id_d = instr_id_q;
    pc_id_d    = pc_id_q;
    pc4_id_d   = pc4_id_q;
    valid_id_d = valid_id_q;
    if (flushE) begin
      instr_id_d = NOP_INSTR;
      valid_id_d = 1'b0;
    end else if (load) begin
      instr_id_d = ld_instr;
      pc_id_d    = ld_pc;
      pc4_id_d   = ld_pc + 32'd4;
      valid_id_d = 1'b1;
    end else if (!stallD) begin
      instr_id_d = NOP_INSTR;
      valid_id_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= S_REQ;
      pc_f_q      <= RESET_PC;
      pc_inf_q    <= 32'd0;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= 32'd0;
      instr_id_q  <= NOP_INSTR;
      pc_id_q     <= 32'd0;
      pc4_id_q    <= 32'd0;
      valid_id_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_f_q      <= pc_f_d;
      pc_inf_q    <= pc_inf_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      instr_id_q  <= instr_id_d;
      pc_id_q     <= pc_id_d;
      pc4_id_q    <= pc4_id_d;
      valid_id_q  <= valid_id_d;
    end
  end

  assign imemReqValid = rstN && (state_q == S_REQ);
  assign imemReqAddr  = pc_f_q;
  assign instrD       = instr_id_q;
  assign pcD          = pc_id_q;
  assign pcPlus4D     = pc4_id_q;
  assign validD       = valid_id_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle table, then random traffic
// against a program-order scoreboard and a one-outstanding memory model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] A0  = 32'h0010_0093;
  localparam logic [31:0] A1  = 32'h0020_0113;
  localparam logic [31:0] A2  = 32'h0030_0193;
  localparam logic [31:0] A3  = 32'h0040_0213;
  localparam logic [31:0] A4  = 32'h0050_0293;
  localparam logic [31:0] A5  = 32'h0060_0313;
  localparam logic [31:0] A6  = 32'h0070_0393;
  localparam logic [31:0] A7  = 32'h0080_0413;
  localparam logic [31:0] A8  = 32'h0090_0493;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] tgt = 32'd0;
  logic        rdy = 1'b0;
  logic        rspv = 1'b0;
  logic [31:0] rspd = 32'd0;
  logic        req_v;
  logic [31:0] req_a;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc4_o;
  logic        vd_o;

  int total = 0;
  int bad = 0;

  fetch_stage dut (
    .clk         (clk),
    .rstN        (rstn),
    .stallD      (stall),
    .flushE      (flush),
    .pcTargetE   (tgt),
    .imemReqValid(req_v),
    .imemReqAddr (req_a),
    .imemReqReady(rdy),
    .imemRspValid(rspv),
    .imemRspData (rspd),
    .instrD      (instr_o),
    .pcD         (pc_o),
    .pcPlus4D    (pc4_o),
    .validD      (vd_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rstn, stall, flush;
    logic [31:0] tgt;
    logic        rdy, rspv;
    logic [31:0] rspd;
    logic        e_rv;
    logic [31:0] e_ra, e_in, e_pc, e_p4;
    logic        e_vd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic r, logic s, logic f, logic [31:0] t,
    logic rd, logic rv, logic [31:0] d,
    logic erv, logic [31:0] era, logic [31:0] ein,
    logic [31:0] epc, logic [31:0] ep4, logic evd);
    vec_t v;
    v.rstn = r; v.stall = s; v.flush = f; v.tgt = t;
    v.rdy = rd; v.rspv = rv; v.rspd = d;
    v.e_rv = erv; v.e_ra = era; v.e_in = ein;
    v.e_pc = epc; v.e_p4 = ep4; v.e_vd = evd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F13;
  endfunction

  // random-phase state
  logic        busy, acc_p, rsp_p;
  int          rem;
  logic [31:0] maddr, addr_p, exp_pc;
  logic        p_stall, p_flush, p_vd;
  logic [31:0] p_tgt, p_in, p_pc, p_p4;
  int          deliv;

  initial begin
    #1 rstn = 1'b0;
    //                rst s f tgt          rdy rsp data  rv addr          instr pc            p4            vd
    vecs.push_back(mk(0, 0, 0, 0,           0, 0, 0,    0, 0,            NOP, 0,            0,            0));
    vecs.push_back(mk(0, 0, 0, 0,           0, 0, 0,    0, 0,            NOP, 0,            0,            0));
    vecs.push_back(mk(1, 0, 0, 0,           1, 0, 0,    1, 32'h0,        NOP, 0,            0,            0));
    vecs.push_back(mk(1, 0, 0, 0,           1, 1, A0,   0, 0,            NOP, 0,            0,            0));
    vecs.push_back(mk(1, 0, 0, 0,           1, 0, 0,    1, 32'h4,        A0,  0,            4,            1));
    vecs.push_back(mk(1, 0, 0, 0,           1, 1, A1,   0, 0,            NOP, 0,            4,            0));
    vecs.push_back(mk(1, 0, 0, 0,           1, 0, 0,    1, 32'h8,        A1,  4,            8,            1));
    vecs.push_back(mk(1, 0, 0, 0,           1, 1, A2,   0, 0,            NOP, 4,            8,            0));
    vecs.push_back(mk(1, 0, 0, 0,           0, 0, 0,    1, 32'hC,        A2,  8,            32'hC,        1));
    vecs.push_back(mk(1, 0, 0, 0,           0, 0, 0,    1, 32'hC,        NOP, 8,            32'hC,        0));
    vecs.push_back(mk(1, 0, 0, 0,           1, 0, 0,    1, 32'hC,        NOP, 8,            32'hC,        0));
    vecs.push_back(mk(1, 0, 0, 0,           1, 0, 0,    0, 0,            NOP, 8,            32'hC,        0));
    vecs.push_back(mk(1, 0, 0, 0,           1, 0, 0,    0, 0,            NOP, 8,            32'hC,        0));
    vecs.push_back(mk(1, 0, 0, 0,           1, 1, A3,   0, 0,            NOP, 8,            32'hC,        0));
    vecs.push_back(mk(1, 1, 0, 0,           1, 0, 0,    1, 32'h10,       A3,  32'hC,        32'h10,       1));
    vecs.push_back(mk(1, 1, 0, 0,           1, 1, A4,   0, 0,            A3,  32'hC,        32'h10,       1));
    vecs.push_back(mk(1, 1, 0, 0,           1, 0, 0,    0, 0,            A3,  32'hC,        32'h10,       1));
    vecs.push_back(mk(1, 1, 0, 0,           1, 0, 0,    0, 0,            A3,  32'hC,        32'h10,       1));
    vecs.push_back(mk(1, 0, 0, 0,           1, 0, 0,    0, 0,            A3,  32'hC,        32'h10,       1));
    vecs.push_back(mk(1, 1, 0, 0,           1, 0, 0,    1, 32'h14,       A4,  32'h10,       32'h14,       1));
    vecs.push_back(mk(1, 1, 1, 32'h100,     0, 0, 0,    0, 0,            A4,  32'h10,       32'h14,       1));
    vecs.push_back(mk(1, 0, 0, 0,           1, 1, A5,   0, 0,            NOP, 32'h10,       32'h14,       0));
    vecs.push_back(mk(1, 0, 0, 0,           1, 0, 0,    1, 32'h100,      NOP, 32'h10,       32'h14,       0));
    vecs.push_back(mk(1, 0, 0, 0,           1, 1, A6,   0, 0,            NOP, 32'h10,       32'h14,       0));
    vecs.push_back(mk(1, 0, 0, 0,           0, 0, 0,    1, 32'h104,      A6,  32'h100,      32'h104,      1));
    vecs.push_back(mk(1, 0, 0, 0,           1, 0, 0,    1, 32'h104,      NOP, 32'h100,      32'h104,      0));
    vecs.push_back(mk(1, 1, 0, 0,           1, 1, A7,   0, 0,            NOP, 32'h100,      32'h104,      0));
    vecs.push_back(mk(1, 1, 1, 32'h200,     1, 0, 0,    0, 0,            NOP, 32'h100,      32'h104,      0));
    vecs.push_back(mk(1, 0, 0, 0,           0, 0, 0,    1, 32'h200,      NOP, 32'h100,      32'h104,      0));
    vecs.push_back(mk(1, 0, 0, 0,           1, 0, 0,    1, 32'h200,      NOP, 32'h100,      32'h104,      0));
    vecs.push_back(mk(0, 0, 0, 0,           0, 0, 0,    0, 0,            NOP, 0,            0,            0));
    vecs.push_back(mk(1, 0, 0, 0,           0, 1, A8,   1, 32'h0,        NOP, 0,            0,            0));
    vecs.push_back(mk(1, 0, 0, 0,           1, 0, 0,    1, 32'h0,        NOP, 0,            0,            0));
    vecs.push_back(mk(1, 0, 0, 0,           1, 1, A0,   0, 0,            NOP, 0,            0,            0));
    vecs.push_back(mk(1, 0, 0, 0,           0, 0, 0,    1, 32'h4,        A0,  0,            4,            1));
    vecs.push_back(mk(1, 0, 1, 32'hFFFFFFFC,0, 0, 0,    1, 32'h4,        NOP, 0,            4,            0));
    vecs.push_back(mk(1, 0, 0, 0,           1, 0, 0,    1, 32'hFFFFFFFC, NOP, 0,            4,            0));
    vecs.push_back(mk(1, 0, 0, 0,           1, 1, A1,   0, 0,            NOP, 0,            4,            0));
    vecs.push_back(mk(1, 0, 0, 0,           0, 0, 0,    1, 32'h0,        A1,  32'hFFFFFFFC, 32'h0,        1));
    vecs.push_back(mk(1, 0, 1, 32'h40,      1, 0, 0,    1, 32'h0,        NOP, 32'hFFFFFFFC, 32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 0,           1, 1, A2,   0, 0,            NOP, 32'hFFFFFFFC, 32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 0,           0, 0, 0,    1, 32'h40,       NOP, 32'hFFFFFFFC, 32'h0,        0));

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rstn = vecs[i].rstn; stall = vecs[i].stall;
      flush = vecs[i].flush; tgt = vecs[i].tgt;
      rdy = vecs[i].rdy; rspv = vecs[i].rspv; rspd = vecs[i].rspd;
      #4;
      chk($sformatf("row%0d reqValid", i), {31'd0, req_v}, {31'd0, vecs[i].e_rv});
      if (vecs[i].e_rv)
        chk($sformatf("row%0d reqAddr", i), req_a, vecs[i].e_ra);
      chk($sformatf("row%0d instrD", i), instr_o, vecs[i].e_in);
      chk($sformatf("row%0d pcD", i), pc_o, vecs[i].e_pc);
      chk($sformatf("row%0d pcPlus4D", i), pc4_o, vecs[i].e_p4);
      chk($sformatf("row%0d validD", i), {31'd0, vd_o}, {31'd0, vecs[i].e_vd});
    end

    // random traffic
    @(posedge clk);
    #1;
    rstn = 1'b0; stall = 1'b0; flush = 1'b0; rdy = 1'b0; rspv = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    busy = 1'b0; acc_p = 1'b0; rsp_p = 1'b0; rem = 0;
    maddr = 32'd0; addr_p = 32'd0; exp_pc = 32'd0;
    p_stall = 1'b0; p_flush = 1'b0; p_vd = 1'b0;
    p_tgt = 32'd0; p_in = NOP; p_pc = 32'd0; p_p4 = 32'd0;
    deliv = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      if (rsp_p) busy = 1'b0;
      if (acc_p) begin
        busy = 1'b1;
        rem = $urandom_range(0, 3);
        maddr = addr_p;
      end else if (busy) begin
        rem--;
      end
      rspv = busy && (rem == 0);
      rspd = mem_word(maddr);
      rdy = ($urandom % 10) < 7;
      stall = ($urandom % 4) == 0;
      flush = ($urandom % 20) == 0;
      tgt = (($urandom % 8) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
      #4;
      if (p_flush) begin
        chk("rnd flush instr", instr_o, NOP);
        chk("rnd flush valid", {31'd0, vd_o}, 32'd0);
        chk("rnd flush pc", pc_o, p_pc);
        exp_pc = p_tgt;
      end else if (p_stall) begin
        chk("rnd stall instr", instr_o, p_in);
        chk("rnd stall pc", pc_o, p_pc);
        chk("rnd stall pc4", pc4_o, p_p4);
        chk("rnd stall valid", {31'd0, vd_o}, {31'd0, p_vd});
      end else if (vd_o) begin
        chk("rnd order pc", pc_o, exp_pc);
        chk("rnd instr", instr_o, mem_word(pc_o));
        chk("rnd pc4", pc4_o, pc_o + 32'd4);
        exp_pc = exp_pc + 32'd4;
        deliv++;
      end else begin
        chk("rnd bubble instr", instr_o, NOP);
        chk("rnd bubble pc", pc_o, p_pc);
        chk("rnd bubble pc4", pc4_o, p_p4);
      end
      chk("rnd one outstanding", {31'd0, req_v & busy}, 32'd0);
      p_stall = stall; p_flush = flush; p_tgt = tgt;
      p_in = instr_o; p_pc = pc_o; p_p4 = pc4_o; p_vd = vd_o;
      acc_p = req_v & rdy;
      addr_p = req_a;
      rsp_p = rspv;
    end
    chk("rnd progress", {31'd0, deliv > 100}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
